comet2_mem_arbiter: RTL

- Two-requester arbiter sharing the single-port program/data RAM (16-bit words, 256-word window, write on negedge mclk, combinational read) between the COMET II CPU (port 0) and a debug/program-loader master (port 1).
- Round-robin grant, registered req/ack handshake, one RAM access per grant.
- Sits between the CPU bus and the RAM model; the RAM itself is unchanged.

---
 rtl/comet2_mem_pkg.sv | 18 +
 rtl/comet2_mem_arbiter_if.sv | 32 +++
 rtl/comet2_rr_pick2.sv | 14 +
 rtl/comet2_mem_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/comet2_mem_pkg.sv
// Shared defaults and encodings for the COMET II memory arbiter.
// Optional build macro: ARB_ADDR_GUARD_EN (out-of-window address guard).
package comet2_mem_pkg;

   localparam int ARB_ADDR_W = 16;
   localparam int ARB_DATA_W = 16;
   localparam int ARB_MEM_AW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DONE  = 2'd2
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/comet2_mem_arbiter_if.sv
// Requester and RAM-side bus of the arbiter. The slave modport is the arbiter,
// the master modport is everything around it (CPU, debug loader, RAM model).
interface comet2_mem_arbiter_if
   import comet2_mem_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
);
   logic              req0, req1;
   logic              wr0, wr1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_waddr, mem_raddr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              busy, err;

   modport slave (
      input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata0, rdata1, mem_we, mem_re, mem_waddr, mem_raddr,
             mem_wdata, busy, err
   );

   modport master (
      output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata0, rdata1, mem_we, mem_re, mem_waddr, mem_raddr,
             mem_wdata, busy, err
   );

endinterface

// File: rtl/comet2_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that was not
// served last wins.
module comet2_rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic gnt_valid,
   output logic gnt_id
);

   assign gnt_valid = req0 | req1;
   assign gnt_id    = (req0 & req1) ? ~last_owner : req1;

endmodule

// File: rtl/comet2_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port program/data RAM.
// One access per grant: IDLE -> SERVE (RAM strobe) -> DONE (ack). Optional
// macro ARB_ADDR_GUARD_EN suppresses accesses above the RAM window and flags err.
module comet2_mem_arbiter
   import comet2_mem_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W,
   parameter int MEM_AW = ARB_MEM_AW
) (
   input  logic                 mclk,
   input  logic                 rst,
   comet2_mem_arbiter_if.slave  bus
);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              wr_q, wr_d;
   logic              bad_q, bad_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic              err_q, err_d;

   logic              gnt_valid, gnt_id, gnt_bad;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] srv_rdata;

   comet2_rr_pick2 u_pick (
      .req0      (bus.req0),
      .req1      (bus.req1),
      .last_owner(last_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign gnt_addr = gnt_id ? bus.addr1 : bus.addr0;

`ifdef ARB_ADDR_GUARD_EN
   assign gnt_bad = |gnt_addr[ADDR_W-1:MEM_AW];
`else
   logic unused_mem_aw;
   assign unused_mem_aw = ^MEM_AW;
   assign gnt_bad       = 1'b0;
`endif

   // A guarded read never reaches the RAM, so it returns zero.
   assign srv_rdata = bad_q ? '0 : bus.mem_rdata;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      wr_d     = wr_q;
      bad_d    = bad_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt_id;
               wr_d    = gnt_id ? bus.wr1 : bus.wr0;
               addr_d  = gnt_addr;
               wdata_d = gnt_id ? bus.wdata1 : bus.wdata0;
               bad_d   = gnt_bad;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (owner_q == PORT_CPU) begin
               ack0_d = 1'b1;
               if (!wr_q) rdata0_d = srv_rdata;
            end else begin
               ack1_d = 1'b1;
               if (!wr_q) rdata1_d = srv_rdata;
            end
            err_d   = bad_q;
            last_d  = owner_q;
            state_d = DONE;
         end
         // Requests are deliberately ignored here so requesters can drop req.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= PORT_CPU;
         last_q   <= PORT_DBG;
         wr_q     <= 1'b0;
         bad_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         wr_q     <= wr_d;
         bad_q    <= bad_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err_q    <= err_d;
      end
   end

   assign bus.mem_we    = (state_q == SERVE) &  wr_q & ~bad_q;
   assign bus.mem_re    = (state_q == SERVE) & ~wr_q & ~bad_q;
   assign bus.mem_waddr = addr_q;
   assign bus.mem_raddr = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.busy      = (state_q == SERVE) | (state_q == DONE);
   assign bus.err       = err_q;

endmodule
